// File: rtl/eth_clk_pkg.sv
// Shared types and default parameters for the Ethernet clock/reset sequencer.
package eth_clk_pkg;

    typedef enum logic [2:0] {
        StResetMmcm,
        StWaitLock,
        StStable,
        StRun,
        StFault
    } state_e;

    localparam int unsigned DefRstPulseCycles   = 16;
    localparam int unsigned DefLockStableCycles = 1024;
    localparam int unsigned DefLockTimeoutCycles = 65536;
    localparam int unsigned DefMaxRetries       = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/eth_sync_2ff.sv
// Generic two-flop single-bit synchronizer with synchronous active-high reset.
module eth_sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/eth_clk_rst_seq.sv
// MMCM reset/lock sequencer and Ethernet-domain reset generator.
module eth_clk_rst_seq
    import eth_clk_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = DefRstPulseCycles,
    parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
    parameter int unsigned MAX_RETRIES         = DefMaxRetries
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               clk_locked_i,
    input  logic                               clear_fault_i,
    output logic                               mmcm_rst_o,
    output logic                               eth_rst_o,
    output logic                               ready_o,
    output logic                               fault_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o
);

    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
    localparam int unsigned CntMax = max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                          LOCK_TIMEOUT_CYCLES);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0]   PulseLast   = CntW'(RST_PULSE_CYCLES - 1);
    localparam logic [CntW-1:0]   StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryLimit  = RetryW'(MAX_RETRIES);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic                mmcm_rst_q, eth_rst_q, ready_q, fault_q;
    logic                lock_s;

    eth_sync_2ff u_lock_sync (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .d_i   (clk_locked_i),
        .q_o   (lock_s)
    );

    // Next-state, shared counter and retry bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        retry_d = retry_q;

        unique case (state_q)
            StResetMmcm: begin
                if (cnt_q == PulseLast) begin
                    state_d = StWaitLock;
                end
            end
            StWaitLock: begin
                // Lock wins over a coincident timeout.
                if (lock_s) begin
                    state_d = StStable;
                end else if (cnt_q == TimeoutLast) begin
                    retry_d = retry_q + RetryW'(1);
                    state_d = (retry_d == RetryLimit) ? StFault : StResetMmcm;
                end
            end
            StStable: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = StResetMmcm;
                end
            end
            StFault: begin
                cnt_d = '0;
                if (clear_fault_i) begin
                    state_d = StResetMmcm;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = StResetMmcm;
            end
        endcase

        if (state_d == StRun) begin
            retry_d = '0;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State, counter and registered outputs decoded from the next state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StResetMmcm;
            cnt_q      <= '0;
            retry_q    <= '0;
            mmcm_rst_q <= 1'b1;
            eth_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            mmcm_rst_q <= (state_d == StResetMmcm) || (state_d == StFault);
            eth_rst_q  <= (state_d != StRun);
            ready_q    <= (state_d == StRun);
            fault_q    <= (state_d == StFault);
        end
    end

    assign mmcm_rst_o  = mmcm_rst_q;
    assign eth_rst_o   = eth_rst_q;
    assign ready_o     = ready_q;
    assign fault_o     = fault_q;
    assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_eth_clk_rst_seq.sv
// Directed bench for eth_clk_rst_seq with a cycle-stamped expectation scoreboard.
module tb_eth_clk_rst_seq;

    localparam int unsigned RstPulse   = 4;
    localparam int unsigned LockStable = 8;
    localparam int unsigned LockTmo    = 32;
    localparam int unsigned MaxRetries = 2;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       clk_locked_i;
    logic       clear_fault_i;
    logic       mmcm_rst_o;
    logic       eth_rst_o;
    logic       ready_o;
    logic       fault_o;
    logic [1:0] retry_cnt_o;

    typedef struct {
        int         cyc;
        logic [5:0] val;
        string      tag;
    } sb_t;

    sb_t sb[$];
    sb_t cur;
    int  cyc = 0;
    int  compared = 0;
    int  mismatched = 0;
    int  t;

    eth_clk_rst_seq #(
        .RST_PULSE_CYCLES    (RstPulse),
        .LOCK_STABLE_CYCLES  (LockStable),
        .LOCK_TIMEOUT_CYCLES (LockTmo),
        .MAX_RETRIES         (MaxRetries)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .clk_locked_i  (clk_locked_i),
        .clear_fault_i (clear_fault_i),
        .mmcm_rst_o    (mmcm_rst_o),
        .eth_rst_o     (eth_rst_o),
        .ready_o       (ready_o),
        .fault_o       (fault_o),
        .retry_cnt_o   (retry_cnt_o)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [5:0] ev(input logic m, input logic e, input logic r,
                                      input logic f, input logic [1:0] rc);
        return {m, e, r, f, rc};
    endfunction

    task automatic push_exp(input int at, input logic [5:0] v, input string tag);
        sb_t s;
        s.cyc = at;
        s.val = v;
        s.tag = tag;
        sb.push_back(s);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) step(1);
    endtask

    // Compare every due expectation plus the output invariants on each falling edge.
    always @(negedge clk_in) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            compared++;
            assert (cur.cyc == cyc &&
                    {mmcm_rst_o, eth_rst_o, ready_o, fault_o, retry_cnt_o} === cur.val)
            else begin
                mismatched++;
                $error("FAIL %s @cyc %0d: observed m/e/r/f/rc=%b expected %b",
                       cur.tag, cyc,
                       {mmcm_rst_o, eth_rst_o, ready_o, fault_o, retry_cnt_o}, cur.val);
            end
        end
        compared++;
        assert (eth_rst_o === ~ready_o && !(ready_o && fault_o))
        else begin
            mismatched++;
            $error("FAIL invariant @cyc %0d: observed eth=%b ready=%b fault=%b expected eth=!ready, not ready&fault",
                   cyc, eth_rst_o, ready_o, fault_o);
        end
    end

    initial begin
        rst_in        = 1'b1;
        clk_locked_i  = 1'b0;
        clear_fault_i = 1'b0;
        step(2);
        push_exp(cyc + 1, ev(1, 1, 0, 0, 0), "reset_vals");
        step(2);

        // Normal bring-up.
        rst_in = 1'b0;
        t = cyc;
        push_exp(t + 1, ev(1, 1, 0, 0, 0), "s1_pulse_first");
        push_exp(t + 3, ev(1, 1, 0, 0, 0), "s1_pulse_last");
        push_exp(t + 4, ev(0, 1, 0, 0, 0), "s1_wait_lock");
        wait_until(t + 14);
        clk_locked_i = 1'b1;
        t = cyc;
        push_exp(t + 10, ev(0, 1, 0, 0, 0), "s1_before_ready");
        push_exp(t + 11, ev(0, 0, 1, 0, 0), "s1_ready");
        wait_until(t + 15);

        // Lock loss in RUN, then re-lock.
        clk_locked_i = 1'b0;
        t = cyc;
        push_exp(t + 2, ev(0, 0, 1, 0, 0), "s4_still_ready");
        push_exp(t + 3, ev(1, 1, 0, 0, 0), "s4_drop");
        push_exp(t + 6, ev(1, 1, 0, 0, 0), "s4_pulse_last");
        push_exp(t + 7, ev(0, 1, 0, 0, 0), "s4_wait_lock");
        wait_until(t + 10);
        clk_locked_i = 1'b1;
        t = cyc;
        push_exp(t + 10, ev(0, 1, 0, 0, 0), "s4_before_ready");
        push_exp(t + 11, ev(0, 0, 1, 0, 0), "s4_ready");
        wait_until(t + 15);

        // Glitchy lock: 5 high, 1 low, then high.
        clk_locked_i = 1'b0;
        t = cyc;
        wait_until(t + 10);
        clk_locked_i = 1'b1;
        t = cyc;
        push_exp(t + 8, ev(0, 1, 0, 0, 0), "s2_back_to_wait");
        push_exp(t + 11, ev(0, 1, 0, 0, 0), "s2_no_early_ready");
        push_exp(t + 16, ev(0, 1, 0, 0, 0), "s2_before_ready");
        push_exp(t + 17, ev(0, 0, 1, 0, 0), "s2_ready");
        step(5);
        clk_locked_i = 1'b0;
        step(1);
        clk_locked_i = 1'b1;
        wait_until(t + 20);

        // Lock synchronized on the timeout cycle.
        clk_locked_i = 1'b0;
        t = cyc;
        wait_until(t + 36);
        clk_locked_i = 1'b1;
        push_exp(t + 39, ev(0, 1, 0, 0, 0), "s6_stable");
        push_exp(t + 40, ev(0, 1, 0, 0, 0), "s6_no_retry");
        push_exp(t + 46, ev(0, 1, 0, 0, 0), "s6_before_ready");
        push_exp(t + 47, ev(0, 0, 1, 0, 0), "s6_ready");
        wait_until(t + 50);

        // Timeout to fault, clear ignored outside FAULT, then clear.
        clk_locked_i = 1'b0;
        t = cyc;
        push_exp(t + 38, ev(0, 1, 0, 0, 0), "s3_wait1_end");
        push_exp(t + 39, ev(1, 1, 0, 0, 1), "s3_retry1");
        push_exp(t + 42, ev(1, 1, 0, 0, 1), "s3_pulse2_last");
        push_exp(t + 43, ev(0, 1, 0, 0, 1), "s3_wait2");
        push_exp(t + 74, ev(0, 1, 0, 0, 1), "s3_wait2_end");
        push_exp(t + 75, ev(1, 1, 0, 1, 2), "s3_fault");
        push_exp(t + 94, ev(1, 1, 0, 1, 2), "s3_fault_sticky");
        push_exp(t + 96, ev(1, 1, 0, 0, 0), "s3_cleared");
        push_exp(t + 99, ev(1, 1, 0, 0, 0), "s3_restart_pulse");
        push_exp(t + 100, ev(0, 1, 0, 0, 0), "s3_restart_wait");
        step(10);
        clear_fault_i = 1'b1;
        step(1);
        clear_fault_i = 1'b0;
        wait_until(t + 95);
        clear_fault_i = 1'b1;
        step(1);
        clear_fault_i = 1'b0;
        wait_until(t + 102);

        // Reset pulse during STABLE.
        clk_locked_i = 1'b1;
        t = cyc;
        push_exp(t + 4, ev(0, 1, 0, 0, 0), "s5_stable");
        push_exp(t + 6, ev(1, 1, 0, 0, 0), "s5_rst_in_stable");
        push_exp(t + 9, ev(1, 1, 0, 0, 0), "s5_pulse_last");
        push_exp(t + 10, ev(0, 1, 0, 0, 0), "s5_wait");
        push_exp(t + 18, ev(0, 1, 0, 0, 0), "s5_before_ready");
        push_exp(t + 19, ev(0, 0, 1, 0, 0), "s5_ready");
        step(5);
        rst_in = 1'b1;
        step(1);
        rst_in = 1'b0;
        wait_until(t + 22);

        // Reset pulse during FAULT.
        clk_locked_i = 1'b0;
        t = cyc;
        push_exp(t + 74, ev(0, 1, 0, 0, 1), "s5f_wait2_end");
        push_exp(t + 75, ev(1, 1, 0, 1, 2), "s5f_fault");
        push_exp(t + 81, ev(1, 1, 0, 0, 0), "s5f_rst_in_fault");
        push_exp(t + 84, ev(1, 1, 0, 0, 0), "s5f_pulse_last");
        push_exp(t + 85, ev(0, 1, 0, 0, 0), "s5f_wait");
        wait_until(t + 80);
        rst_in = 1'b1;
        step(1);
        rst_in = 1'b0;
        wait_until(t + 88);

        step(3);
        compared++;
        assert (sb.size() == 0)
        else begin
            mismatched++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
